// File: rtl/wb_neuron_loader.sv
// Wishbone classic master that bursts words into and out of the neuron core window.
// Optional per-beat ack timeout is enabled by defining WB_LOADER_TIMEOUT_EN.
module wb_neuron_loader #(
  parameter int LEN_W   = 12,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_adr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [31:0]      wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [31:0]      rd_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    BUS,
    RESP,
    NEXT
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] remaining;

  if (TIMEOUT >= (1 << TO_W)) begin : g_bad_cfg
    $error("TO_W too narrow for TIMEOUT");
  end

  assign cmd_ready = (state == IDLE);
  assign wr_ready  = (state == FETCH);

`ifdef WB_LOADER_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'h0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
`ifdef WB_LOADER_TIMEOUT_EN
      to_cnt    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef WB_LOADER_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            wbm_adr_o <= cmd_adr & 32'hFFFF_FFFC;
            wbm_we_o  <= cmd_we;
            remaining <= cmd_len;
            busy      <= 1'b1;
            if (cmd_we) begin
              state <= FETCH;
            end else begin
              state     <= BUS;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_sel_o <= 4'hF;
`ifdef WB_LOADER_TIMEOUT_EN
              to_cnt    <= '0;
`endif
            end
          end
        end
        FETCH: begin
          if (wr_valid) begin
            wbm_dat_o <= wr_data;
            state     <= BUS;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_sel_o <= 4'hF;
`ifdef WB_LOADER_TIMEOUT_EN
            to_cnt    <= '0;
`endif
          end
        end
        BUS: begin
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_sel_o <= 4'h0;
            if (wbm_we_o) begin
              state <= NEXT;
            end else begin
              rd_data  <= wbm_dat_i;
              rd_valid <= 1'b1;
              state    <= RESP;
            end
          end
`ifdef WB_LOADER_TIMEOUT_EN
          else if (to_cnt == TO_MAX) begin
            // dead slave: abandon the rest of the burst
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_sel_o <= 4'h0;
            err_q     <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            state    <= NEXT;
          end
        end
        NEXT: begin
          if (remaining == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wbm_adr_o <= wbm_adr_o + 32'd4;
            remaining <= remaining - 1'b1;
            if (wbm_we_o) begin
              state <= FETCH;
            end else begin
              state     <= BUS;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_sel_o <= 4'hF;
`ifdef WB_LOADER_TIMEOUT_EN
              to_cnt    <= '0;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_neuron_loader.sv
// Scoreboard bench for wb_neuron_loader: expected bus beats and read words
// are queued by the stimulus and checked by an independent monitor.
module tb_wb_neuron_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr;
  logic [11:0] cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        busy, done, err;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;
  logic        ack;

  always #5 clk = ~clk;

  wb_neuron_loader dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
    .wbm_sel_o(sel), .wbm_adr_o(adr), .wbm_dat_o(dat_o),
    .wbm_ack_i(ack), .wbm_dat_i(dat_i)
  );

  // slave: ack rises when its wait counter reaches dly
  int dly  = 1;
  bit dead = 0;
  int wcnt = 0;
  assign dat_i = adr ^ 32'hA5A5_A5A5;

  always @(posedge clk) begin
    if (rst || !(cyc && stb) || ack) begin
      ack  <= 1'b0;
      wcnt <= 0;
    end else if (!dead) begin
      if (wcnt >= dly) ack <= 1'b1;
      else wcnt <= wcnt + 1;
    end
  end

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
  } beat_t;

  beat_t       exp_bus[$];
  logic [31:0] exp_rd[$];
  int tests = 0, fails = 0;
  int done_cnt = 0, err_cnt = 0, rdv_cnt = 0, cyc_cycles = 0;
  int exp_done = 0, exp_err = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // monitor
  bit          p_bus = 0, p_ack = 0, p_stall = 0;
  logic [31:0] p_adr, p_rd;

  always @(negedge clk) begin
    if (!rst) begin
      if (cyc) cyc_cycles++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (p_bus) begin
        chk("bus_hold_stb", {31'd0, cyc & stb}, 1);
        chk("bus_hold_adr", adr, p_adr);
      end
      if (p_ack) chk("idle_after_ack", {31'd0, cyc}, 0);
      if (wr_ready) chk("no_bus_in_fetch", {31'd0, cyc}, 0);
      if (rd_valid) chk("no_bus_in_resp", {31'd0, cyc}, 0);
      if (p_stall) begin
        chk("rd_valid_hold", {31'd0, rd_valid}, 1);
        chk("rd_data_hold", rd_data, p_rd);
      end
      if (cyc && stb && ack) begin
        if (exp_bus.size() == 0) begin
          chk("bus_unexpected_adr", adr, 32'hxxxx_xxxx);
        end else begin
          beat_t b;
          b = exp_bus.pop_front();
          chk("bus_adr", adr, b.a);
          chk("bus_we", {31'd0, we}, {31'd0, b.w});
          chk("bus_sel", {28'd0, sel}, 32'hF);
          if (b.w) chk("bus_dat", dat_o, b.d);
        end
      end
      if (rd_valid && rd_ready) begin
        rdv_cnt++;
        if (exp_rd.size() == 0) chk("rd_unexpected", rd_data, 32'hxxxx_xxxx);
        else chk("rd_data", rd_data, exp_rd.pop_front());
      end
    end
    p_bus   = cyc && stb && !ack && !rst;
    p_ack   = cyc && stb && ack && !rst;
    p_stall = rd_valid && !rd_ready && !rst;
    p_adr   = adr;
    p_rd    = rd_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bus(input logic [31:0] a, input logic w, input logic [31:0] d);
    beat_t b;
    b.a = a; b.w = w; b.d = d;
    exp_bus.push_back(b);
  endtask

  task automatic send_cmd(input logic w, input logic [31:0] a, input int len);
    int n = 0;
    cmd_we = w; cmd_adr = a; cmd_len = 12'(len); cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_wr(input logic [31:0] d, input int stall);
    int n = 0;
    repeat (stall) tick();
    wr_data = d; wr_valid = 1'b1;
    while (!wr_ready && n < 1000) begin tick(); n++; end
    chk("wr_ready_wait", {31'd0, wr_ready}, 1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt < exp_done && n < budget) begin tick(); n++; end
    chk("done_seen", done_cnt, exp_done);
    tick();
    chk("busy_after_done", {31'd0, busy}, 0);
    chk("cmd_ready_after_done", {31'd0, cmd_ready}, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_len = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 1;
    repeat (3) tick();
    chk("rst_cyc", {31'd0, cyc}, 0);
    chk("rst_stb", {31'd0, stb}, 0);
    chk("rst_sel", {28'd0, sel}, 0);
    chk("rst_adr", adr, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rdv", {31'd0, rd_valid}, 0);
    chk("rst_done_err", {30'd0, done, err}, 0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    rst = 1'b0;
    tick();

    // single write
    dly = 1;
    push_bus(32'h3000_0000, 1, 32'hDEAD_BEEF);
    exp_done++;
    send_cmd(1, 32'h3000_0000, 0);
    chk("busy_during", {31'd0, busy}, 1);
    send_wr(32'hDEAD_BEEF, 0);
    wait_done(100);

    // read burst of four
    dly = 0;
    for (int i = 0; i < 4; i++) begin
      push_bus(32'h3000_8000 + 32'(4 * i), 0, 0);
      exp_rd.push_back((32'h3000_8000 + 32'(4 * i)) ^ 32'hA5A5_A5A5);
    end
    exp_done++;
    send_cmd(0, 32'h3000_8000, 3);
    wait_done(200);

    // write backpressure
    dly = 2;
    push_bus(32'h3000_0200, 1, 32'h0102_0304);
    push_bus(32'h3000_0204, 1, 32'hCAFE_F00D);
    exp_done++;
    send_cmd(1, 32'h3000_0200, 1);
    send_wr(32'h0102_0304, 0);
    send_wr(32'hCAFE_F00D, 5);
    wait_done(100);

    // read backpressure
    dly = 0;
    rd_ready = 1'b0;
    push_bus(32'h3000_0300, 0, 0);
    push_bus(32'h3000_0304, 0, 0);
    exp_rd.push_back(32'h3000_0300 ^ 32'hA5A5_A5A5);
    exp_rd.push_back(32'h3000_0304 ^ 32'hA5A5_A5A5);
    exp_done++;
    send_cmd(0, 32'h3000_0300, 1);
    begin
      int n = 0;
      while (!rd_valid && n < 100) begin tick(); n++; end
      chk("rd_valid_seen", {31'd0, rd_valid}, 1);
    end
    repeat (5) tick();
    rd_ready = 1'b1;
    wait_done(100);

    // address wrap and alignment
    push_bus(32'hFFFF_FFFC, 0, 0);
    push_bus(32'h0000_0000, 0, 0);
    exp_rd.push_back(32'hFFFF_FFFC ^ 32'hA5A5_A5A5);
    exp_rd.push_back(32'h0000_0000 ^ 32'hA5A5_A5A5);
    exp_done++;
    send_cmd(0, 32'hFFFF_FFFE, 1);
    wait_done(100);

`ifdef WB_LOADER_TIMEOUT_EN
    // dead slave
    begin
      int n = 0;
      int rd0 = rdv_cnt;
      dead = 1;
      cyc_cycles = 0;
      exp_err++;
      send_cmd(0, 32'h3000_0400, 2);
      while (err_cnt < exp_err && n < 400) begin tick(); n++; end
      repeat (4) tick();
      chk("to_err", err_cnt, exp_err);
      chk("to_cyc_cycles", cyc_cycles, 256);
      chk("to_no_done", done_cnt, exp_done);
      chk("to_no_rd", rdv_cnt, rd0);
      chk("to_cmd_ready", {31'd0, cmd_ready}, 1);
      chk("to_busy", {31'd0, busy}, 0);
      dead = 0;
    end
    // ack in the final allowed cycle
    dly = 254;
    cyc_cycles = 0;
    push_bus(32'h3000_0500, 0, 0);
    exp_rd.push_back(32'h3000_0500 ^ 32'hA5A5_A5A5);
    exp_done++;
    send_cmd(0, 32'h3000_0500, 0);
    wait_done(400);
    chk("late_ack_no_err", err_cnt, exp_err);
    chk("late_ack_cyc", cyc_cycles, 256);
`endif

    // reset in the middle of beat 2
    dly = 3;
    push_bus(32'h3000_1000, 1, 32'h1111_1111);
    send_cmd(1, 32'h3000_1000, 7);
    send_wr(32'h1111_1111, 0);
    send_wr(32'h2222_2222, 0);
    chk("beat2_active", {31'd0, cyc}, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_cyc", {31'd0, cyc}, 0);
    chk("mid_rst_stb", {31'd0, stb}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_pulses", {30'd0, done, err}, 0);
    rst = 1'b0;
    tick();
    dly = 1;
    push_bus(32'h3000_2000, 1, 32'h1234_5678);
    exp_done++;
    send_cmd(1, 32'h3000_2000, 0);
    send_wr(32'h1234_5678, 0);
    wait_done(100);

    repeat (3) tick();
    chk("bus_queue_empty", exp_bus.size(), 0);
    chk("rd_queue_empty", exp_rd.size(), 0);
    chk("done_total", done_cnt, exp_done);
    chk("err_total", err_cnt, exp_err);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
